uart_tx_arb: RTL and testbench

UART_TX_ARB -- requirements
Module: uart_tx_arb

---
 rtl/uart_tx_arb.sv | 168 ++++++++++++++++
 tb/tb_uart_tx_arb.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter feeding one UART transmitter from four requesters; grant one cycle after request, byte strobed one cycle after SEND.
// Backpressure: holds off while tx_busy is high; bursts rotate after MAX_BURST bytes; a missing busy acknowledge times out after BUSY_TIMEOUT cycles.
module uart_tx_arb #(
    parameter int          NREQ         = 4,
    parameter logic [7:0]  MAX_BURST    = 8'd16,
    parameter logic [7:0]  BUSY_TIMEOUT = 8'd16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ack,
    output logic [NREQ-1:0]   grant,
    output logic [7:0]        tx_data,
    output logic              tx_pluse,
    input  logic              tx_busy,
    output logic              timeout_err,
    output logic              active
);

    localparam int IW = $clog2(NREQ);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_SEND      = 2'd1;
    localparam logic [1:0] S_WAIT_BUSY = 2'd2;
    localparam logic [1:0] S_WAIT_IDLE = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [IW-1:0]   own_q, own_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [7:0]      burst_q, burst_d;
    logic [7:0]      wait_q, wait_d;
    logic            last_q, last_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            tx_pluse_q, tx_pluse_d;
    logic [NREQ-1:0] req_ack_q, req_ack_d;
    logic            timeout_err_q, timeout_err_d;
    logic            active_q, active_d;

    logic            pick_vld;
    logic [IW-1:0]   pick_idx;
    logic [IW-1:0]   cand;
    logic [7:0]      wait_inc;

    // First requesting index at or after ptr, wrapping.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = ptr_q + IW'(k);
            if (!pick_vld && req[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        own_d         = own_q;
        ptr_d         = ptr_q;
        burst_d       = burst_q;
        wait_d        = wait_q;
        last_d        = last_q;
        tx_data_d     = tx_data_q;
        tx_pluse_d    = 1'b0;
        req_ack_d     = '0;
        timeout_err_d = 1'b0;
        wait_inc      = wait_q + 8'd1;

        case (state_q)
            S_IDLE: begin
                if (pick_vld && !tx_busy) begin
                    own_d   = pick_idx;
                    grant_d = NREQ'(1) << pick_idx;
                    burst_d = 8'd0;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (!req[own_q]) begin
                    grant_d = '0;
                    ptr_d   = own_q + IW'(1);
                    burst_d = 8'd0;
                    state_d = S_IDLE;
                end else if (!tx_busy) begin
                    tx_data_d  = req_data[{own_q, 3'b000} +: 8];
                    last_d     = req_last[own_q];
                    tx_pluse_d = 1'b1;
                    req_ack_d  = NREQ'(1) << own_q;
                    wait_d     = 8'd0;
                    if (burst_q != 8'hFF) begin
                        burst_d = burst_q + 8'd1;
                    end
                    state_d = S_WAIT_BUSY;
                end
            end
            S_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = S_WAIT_IDLE;
                end else begin
                    wait_d = wait_inc;
                    // The byte is already counted in burst_q, so a timeout just moves on.
                    if (wait_inc == BUSY_TIMEOUT) begin
                        timeout_err_d = 1'b1;
                        state_d       = S_WAIT_IDLE;
                    end
                end
            end
            default: begin
                if (!tx_busy) begin
                    if (last_q || (burst_q >= MAX_BURST)) begin
                        grant_d = '0;
                        ptr_d   = own_q + IW'(1);
                        burst_d = 8'd0;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_SEND;
                    end
                end
            end
        endcase

        active_d = |grant_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            grant_q       <= '0;
            own_q         <= '0;
            ptr_q         <= '0;
            burst_q       <= 8'd0;
            wait_q        <= 8'd0;
            last_q        <= 1'b0;
            tx_data_q     <= 8'h00;
            tx_pluse_q    <= 1'b0;
            req_ack_q     <= '0;
            timeout_err_q <= 1'b0;
            active_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            own_q         <= own_d;
            ptr_q         <= ptr_d;
            burst_q       <= burst_d;
            wait_q        <= wait_d;
            last_q        <= last_d;
            tx_data_q     <= tx_data_d;
            tx_pluse_q    <= tx_pluse_d;
            req_ack_q     <= req_ack_d;
            timeout_err_q <= timeout_err_d;
            active_q      <= active_d;
        end
    end

    assign grant       = grant_q;
    assign req_ack     = req_ack_q;
    assign tx_data     = tx_data_q;
    assign tx_pluse    = tx_pluse_q;
    assign timeout_err = timeout_err_q;
    assign active      = active_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: requester queues and a busy-pulse transmitter model drive the DUT;
// a packet-level arbitration model predicts the (owner, byte) order checked on every strobe.
module tb_uart_tx_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ack;
    logic [3:0]  grant;
    logic [7:0]  tx_data;
    logic        tx_pluse;
    logic        tx_busy;
    logic        timeout_err;
    logic        active;

    int total = 0;
    int bad   = 0;

    // Requester byte streams: {last, byte}; rd_idx advances on each ack.
    logic [8:0] src_q[4][$];
    int         rd_idx[4];
    // Expected strobes: {owner, byte}.
    logic [9:0] exp_q[$];
    int         exp_rd    = 0;
    int         busy_len  = 10;
    int         force_end = 0;
    int         cyc       = 0;
    int         mdl_ptr   = 0;
    bit         chk_on    = 1'b0;
    int         to_seen   = 0;

    uart_tx_arb dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ack    (req_ack),
        .grant      (grant),
        .tx_data    (tx_data),
        .tx_pluse   (tx_pluse),
        .tx_busy    (tx_busy),
        .timeout_err(timeout_err),
        .active     (active)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, expv);
        end
    endtask

    function automatic bit srcs_empty();
        bit e = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (rd_idx[i] < src_q[i].size()) e = 1'b0;
        end
        return e;
    endfunction

    // Packet-level arbitration: pick first non-empty queue from ptr, send until last flag,
    // 16 bytes, or the queue runs dry, then ptr = owner + 1.
    task automatic run_model();
        logic [8:0] mq[4][$];
        logic [8:0] e;
        int  g;
        int  n;
        bit  found;
        bit  done;
        bit  more = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mq[i].delete();
            for (int j = rd_idx[i]; j < src_q[i].size(); j++) mq[i].push_back(src_q[i][j]);
        end
        while (more) begin
            found = 1'b0;
            g = 0;
            for (int k = 0; k < 4; k++) begin
                if (!found && mq[(mdl_ptr + k) % 4].size() > 0) begin
                    found = 1'b1;
                    g = (mdl_ptr + k) % 4;
                end
            end
            if (!found) begin
                more = 1'b0;
            end else begin
                n = 0;
                done = 1'b0;
                while (!done) begin
                    if (mq[g].size() == 0) begin
                        done = 1'b1;
                    end else begin
                        e = mq[g].pop_front();
                        exp_q.push_back({2'(g), e[7:0]});
                        n++;
                        if (e[8] || n == 16) done = 1'b1;
                    end
                end
                mdl_ptr = (g + 1) % 4;
            end
        end
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_grant"}, grant, 0);
        chk({nm, "_active"}, active, 0);
        chk({nm, "_pluse"}, tx_pluse, 0);
        chk({nm, "_ack"}, req_ack, 0);
        chk({nm, "_timeout"}, timeout_err, 0);
        chk({nm, "_txdata"}, tx_data, 0);
    endtask

    task automatic wait_done(input string nm, input int budget);
        int n = 0;
        bit ok = 1'b0;
        while (!ok && n < budget) begin
            @(posedge clk); #2;
            n++;
            ok = (exp_rd == exp_q.size()) && (grant == 4'b0) && !tx_busy && srcs_empty();
        end
        chk({nm, "_done"}, ok, 1);
        repeat (4) @(posedge clk);
        #2;
    endtask

    // Environment: transmitter busy model and requester drivers, updated just after each edge.
    initial begin
        logic [8:0] e;
        int busy_cnt = 0;
        bit start_pend = 1'b0;
        tx_busy = 1'b0; req = '0; req_data = '0; req_last = '0;
        for (int i = 0; i < 4; i++) rd_idx[i] = 0;
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (start_pend) begin
                busy_cnt = busy_len;
                start_pend = 1'b0;
            end
            tx_busy = (busy_cnt > 0) || (cyc < force_end);
            if (busy_cnt > 0) busy_cnt--;
            if (tx_pluse) start_pend = 1'b1;
            for (int i = 0; i < 4; i++) begin
                if (req_ack[i]) rd_idx[i]++;
                if (rd_idx[i] < src_q[i].size()) begin
                    e = src_q[i][rd_idx[i]];
                    req[i] = 1'b1;
                    req_data[8*i +: 8] = e[7:0];
                    req_last[i] = e[8];
                end else begin
                    req[i] = 1'b0;
                    req_last[i] = 1'b0;
                end
            end
        end
    end

    // Compare process: invariants every cycle, expected byte/owner on each strobe, timeout timing.
    initial begin
        logic [9:0] e;
        logic prev_busy = 1'b0;
        bit armed = 1'b0;
        bit seen = 1'b0;
        bit exp_to;
        int since = 0;
        forever begin
            @(negedge clk);
            exp_to = 1'b0;
            if (tx_pluse) begin
                armed = 1'b1; since = 0; seen = tx_busy;
            end else if (armed) begin
                since++;
                exp_to = !seen && (since == 16);
                if (since >= 16) armed = 1'b0;
                seen = seen | tx_busy;
            end
            if (rst) begin
                armed = 1'b0;
                exp_to = 1'b0;
            end
            if (chk_on) begin
                chk("active_vs_grant", active, |grant);
                chk("grant_onehot0", $onehot0(grant), 1);
                chk("ack_onehot0", $onehot0(req_ack), 1);
                chk("ack_with_pluse", |req_ack, tx_pluse);
                chk("timeout_err", timeout_err, exp_to);
                if (timeout_err) to_seen++;
                if (tx_pluse) begin
                    chk("pluse_prev_busy", prev_busy, 0);
                    chk("pluse_busy_now", tx_busy, 0);
                    if (exp_rd < exp_q.size()) begin
                        e = exp_q[exp_rd];
                        exp_rd++;
                        chk("tx_data", tx_data, e[7:0]);
                        chk("req_ack_owner", req_ack, 4'b0001 << e[9:8]);
                        chk("grant_owner", grant, 4'b0001 << e[9:8]);
                    end else begin
                        chk("unexpected_pluse", tx_pluse, 0);
                    end
                end
            end
            prev_busy = tx_busy;
        end
    end

    initial begin
        int base;
        int to_before;
        int n;
        bit got;
        logic [9:0] ev;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check_zero("rst0");
        rst = 1'b0;
        chk_on = 1'b1;

        // Single packet 41,42,43 from requester 0.
        busy_len = 10;
        src_q[0].push_back(9'h041); src_q[0].push_back(9'h042); src_q[0].push_back(9'h143);
        base = exp_q.size();
        run_model();
        chk("s1_count", exp_q.size() - base, 3);
        ev = exp_q[base];     chk("s1_e0", ev, 10'h041);
        ev = exp_q[base + 1]; chk("s1_e1", ev, 10'h042);
        ev = exp_q[base + 2]; chk("s1_e2", ev, 10'h043);
        chk("s1_ptr", mdl_ptr, 1);
        wait_done("s1", 2000);

        // Reset, then alternating single-byte packets from requesters 0 and 1.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        check_zero("rst1");
        rst = 1'b0;
        mdl_ptr = 0;
        for (int j = 0; j < 3; j++) begin
            src_q[0].push_back(9'h1A0 + 9'(j));
            src_q[1].push_back(9'h1B0 + 9'(j));
        end
        base = exp_q.size();
        run_model();
        for (int k = 0; k < 6; k++) begin
            ev = exp_q[base + k];
            chk("s2_owner", ev[9:8], k % 2);
        end
        chk("s2_ptr", mdl_ptr, 2);
        wait_done("s2", 2000);

        // Long packet from requester 2 is cut at 16 bytes in favour of requester 3.
        busy_len = 2;
        for (int j = 0; j < 20; j++) src_q[2].push_back(9'h080 + 9'(j));
        src_q[3].push_back(9'h1C0); src_q[3].push_back(9'h1C1);
        base = exp_q.size();
        run_model();
        chk("s3_count", exp_q.size() - base, 22);
        ev = exp_q[base + 15]; chk("s3_own15", ev[9:8], 2);
        ev = exp_q[base + 16]; chk("s3_own16", ev, 10'h3C0);
        ev = exp_q[base + 17]; chk("s3_own17", ev, 10'h290);
        ev = exp_q[base + 21]; chk("s3_own21", ev, 10'h3C1);
        chk("s3_ptr", mdl_ptr, 0);
        wait_done("s3", 3000);

        // Transmitter never raises busy: every byte times out, burst still completes.
        busy_len = 0;
        to_before = to_seen;
        src_q[1].push_back(9'h071); src_q[1].push_back(9'h172);
        base = exp_q.size();
        run_model();
        ev = exp_q[base]; chk("s4_e0", ev, 10'h171);
        chk("s4_ptr", mdl_ptr, 2);
        wait_done("s4", 2000);
        chk("s4_timeouts", to_seen - to_before, 2);

        // Owner 2 drops req after one byte; grant is released and requester 0 follows.
        busy_len = 3;
        src_q[2].push_back(9'h061);
        src_q[0].push_back(9'h162);
        base = exp_q.size();
        run_model();
        ev = exp_q[base];     chk("s5_e0", ev, 10'h261);
        ev = exp_q[base + 1]; chk("s5_e1", ev, 10'h062);
        chk("s5_ptr", mdl_ptr, 1);
        wait_done("s5", 2000);

        // Reset while waiting for busy; busy held high afterwards blocks any new grant.
        busy_len = 0;
        src_q[1].push_back(9'h051); src_q[1].push_back(9'h152);
        exp_q.push_back(10'h151);
        got = 1'b0;
        n = 0;
        while (!got && n < 200) begin
            @(posedge clk); #2;
            n++;
            got = tx_pluse;
        end
        chk("s6_first_pluse", got, 1);
        rst = 1'b1;
        force_end = cyc + 7;
        @(posedge clk); #2;
        rst = 1'b0;
        check_zero("s6_rst");
        mdl_ptr = 0;
        base = exp_q.size();
        run_model();
        ev = exp_q[base]; chk("s6_e0", ev, 10'h152);
        n = 0;
        while (tx_busy && n < 20) begin
            chk("s6_no_grant_busy", grant, 0);
            @(posedge clk); #2;
            n++;
        end
        chk("s6_busy_fell", tx_busy, 0);
        wait_done("s6", 2000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
